eco_vector_sweeper: RTL and testbench

//  Exhaustive stimulus/check stage wrapped around an ECO-patched combinational

---
 rtl/eco_vector_sweeper.sv | 118 +++++++++++
 tb/tb_eco_vector_sweeper.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/eco_vector_sweeper.sv
// Exhaustive {a,b} sweep around an ECO-patched combinational netlist, comparing y against a golden y.
// Optional build macro: ECO_SWEEP_STOP_ON_FAIL_EN (halt the sweep on the first mismatching vector).
module eco_vector_sweeper #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [IN_W-1:0]     a_o,
  output logic [IN_W-1:0]     b_o,
  input  logic [OUT_W-1:0]    y_impl_i,
  input  logic [OUT_W-1:0]    y_gold_i,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2*IN_W:0]     mismatch_cnt,
  output logic                first_fail_valid,
  output logic [2*IN_W-1:0]   first_fail_vec
);

  localparam int VW  = 2 * IN_W;
  localparam int CW  = 2 * IN_W + 1;
  localparam int SCW = $clog2(SETTLE + 1) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // First vector settles one extra cycle to cover the registered launch of a_o/b_o.
  localparam logic [SCW-1:0] SETTLE_FIRST  = SCW'(SETTLE);
  localparam logic [SCW-1:0] SETTLE_RELOAD = SCW'(SETTLE - 1);

  logic [1:0]     state;
  logic [VW-1:0]  vec;
  logic [SCW-1:0] settle_cnt;
  logic           mismatch;
  logic           last_vec;
  logic           cnt_sat;
  logic           stop_now;

  assign mismatch = (y_impl_i != y_gold_i);
  assign last_vec = &vec;
  assign cnt_sat  = &mismatch_cnt;

`ifdef ECO_SWEEP_STOP_ON_FAIL_EN
  assign stop_now = last_vec || mismatch;
`else
  assign stop_now = last_vec;
`endif

  assign a_o  = vec[VW-1:IN_W];
  assign b_o  = vec[IN_W-1:0];
  assign pass = done && (mismatch_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      vec              <= '0;
      settle_cnt       <= '0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state            <= ST_SETTLE;
            vec              <= '0;
            settle_cnt       <= SETTLE_FIRST;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - SCW'(1);
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (!cnt_sat) begin
              mismatch_cnt <= mismatch_cnt + CW'(1);
            end
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= vec;
            end
          end
          if (stop_now) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= ST_SETTLE;
            vec        <= vec + VW'(1);
            settle_cnt <= SETTLE_RELOAD;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eco_vector_sweeper.sv
// Self-checking bench for eco_vector_sweeper: directed vector table plus randomized fault maps
// checked against a sweep-level reference model.
module tb_eco_vector_sweeper;

  localparam int IN_W  = 4;
  localparam int OUT_W = 4;
  localparam int S     = 1;
  localparam int NV    = 1 << (2 * IN_W);
`ifdef ECO_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [IN_W-1:0]    a_o, b_o;
  logic [OUT_W-1:0]   y_impl, y_gold;
  logic               busy, done, pass, first_fail_valid;
  logic [2*IN_W:0]    mismatch_cnt;
  logic [2*IN_W-1:0]  first_fail_vec;

  logic [OUT_W-1:0]   err_mask [NV];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Netlist stand-ins: impl is a 4-bit adder, golden differs by err_mask per vector.
  always_comb begin
    y_impl = OUT_W'(a_o + b_o);
    y_gold = y_impl ^ err_mask[{a_o, b_o}];
  end

  eco_vector_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(a_o), .b_o(b_o),
    .y_impl_i(y_impl), .y_gold_i(y_gold), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_valid(first_fail_valid),
    .first_fail_vec(first_fail_vec)
  );

  typedef struct {
    string name;
    int    mode;     // 0 clean, 1 single vector, 2 all inverted
    int    target;
    int    exp_cnt;
    int    exp_valid;
    int    exp_ffv;
    int    exp_lat;
    int    exp_end;
    bit    repulse;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  function automatic vec_t mk(string nm, int mode, int tgt, int cnt, int vld, int ffv,
                              int lat, int endv, bit rep);
    vec_t t;
    t.name = nm; t.mode = mode; t.target = tgt; t.exp_cnt = cnt; t.exp_valid = vld;
    t.exp_ffv = ffv; t.exp_lat = lat; t.exp_end = endv; t.repulse = rep;
    return t;
  endfunction

  task automatic set_mask(input int mode, input int tgt);
    for (int v = 0; v < NV; v++) begin
      if (mode == 2) err_mask[v] = '1;
      else if (mode == 1 && v == tgt) err_mask[v] = 4'b0001;
      else err_mask[v] = '0;
    end
  endtask

  // Reference: walk vectors in order; each costs S+1 cycles, plus one launch cycle.
  task automatic model(output int cnt, output int vld, output int ffv, output int lat,
                       output int endv);
    int last;
    cnt = 0; vld = 0; ffv = 0; last = NV - 1;
    for (int v = 0; v < NV; v++) begin
      if (err_mask[v] != 0) begin
        cnt++;
        if (vld == 0) begin vld = 1; ffv = v; end
        if (STOP) begin last = v; break; end
      end
    end
    lat  = 1 + (last + 1) * (S + 1);
    endv = last;
  endtask

  task automatic run_sweep(input vec_t t);
    int  n;
    bit  repulsed;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    repulsed = 1'b0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      if (start) start = 1'b0;
      if (n == 1) begin
        chk({t.name, " busy_early"}, busy, 1);
        chk({t.name, " done_early"}, done, 0);
      end
      if (done) break;
      if (t.repulse && !repulsed && {a_o, b_o} == 8'h40) begin
        start = 1'b1;
        repulsed = 1'b1;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s timeout: done not seen after %0d cycles, expected at %0d", t.name, n, t.exp_lat);
    end
    chk({t.name, " latency"}, n, t.exp_lat);
    chk({t.name, " busy_at_done"}, busy, 0);
    chk({t.name, " pass"}, pass, (t.exp_cnt == 0) ? 1 : 0);
    chk({t.name, " mismatch_cnt"}, mismatch_cnt, t.exp_cnt);
    chk({t.name, " ff_valid"}, first_fail_valid, t.exp_valid);
    chk({t.name, " ff_vec"}, first_fail_vec, t.exp_ffv);
    chk({t.name, " end_vec"}, {a_o, b_o}, t.exp_end);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " a_o"}, a_o, 0);
    chk({nm, " b_o"}, b_o, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " pass"}, pass, 0);
    chk({nm, " cnt"}, mismatch_cnt, 0);
    chk({nm, " ff_valid"}, first_fail_valid, 0);
    chk({nm, " ff_vec"}, first_fail_vec, 0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t r;
    int   cnt, vld, ffv, lat, endv, d, n;

    tbl.push_back(mk("clean",   0, 0,    0, 0, 0, 513, 255, 0));
    tbl.push_back(mk("repulse", 0, 0,    0, 0, 0, 513, 255, 1));
    tbl.push_back(mk("one_35",  1, 8'h35, 1, 1, 8'h35, STOP ? 109 : 513, STOP ? 8'h35 : 255, 0));
    tbl.push_back(mk("all_inv", 2, 0,    STOP ? 1 : 256, 1, 0, STOP ? 3 : 513, STOP ? 0 : 255, 0));
    tbl.push_back(mk("one_00",  1, 0,    1, 1, 0, STOP ? 3 : 513, STOP ? 0 : 255, 0));
    tbl.push_back(mk("one_ff",  1, 255,  1, 1, 255, 513, 255, 0));
    tbl.push_back(mk("one_10",  1, 8'h10, 1, 1, 8'h10, STOP ? 35 : 513, STOP ? 8'h10 : 255, 0));

    set_mask(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      set_mask(tbl[i].mode, tbl[i].target);
      run_sweep(tbl[i]);
    end

    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(0, 3);
      for (int v = 0; v < NV; v++)
        err_mask[v] = ($urandom_range(0, 99) < d) ? OUT_W'($urandom_range(1, 15)) : '0;
      model(cnt, vld, ffv, lat, endv);
      r = mk($sformatf("rand%0d", k), 3, 0, cnt, vld, ffv, lat, endv, 0);
      run_sweep(r);
    end

    // Start held high in DONE restarts; then reset lands mid-sweep.
    set_mask(2, 0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    chk("restart busy", busy, 1);
    chk("restart done", done, 0);
    chk("restart cnt", mismatch_cnt, 0);
    start = 1'b0;
    n = 0;
    while (n < 1000 && {a_o, b_o} != 8'h80) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("reach_80", {a_o, b_o}, 8'h80);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_all_zero("midreset");
    set_mask(0, 0);
    run_sweep(mk("post_reset", 0, 0, 0, 0, 0, 513, 255, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
